// File: rtl/branch_resolve_unit.sv
// Branch resolution in AGEX: tracks in-flight predictions in order, trains the
// predictor on every resolve and redirects fetch (squashing younger work) on a mispredict.
module branch_resolve_unit #(
    parameter int unsigned DBITS  = 32,
    parameter int unsigned BPBITS = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [DBITS-1:0]         pred_pc,
    input  logic [DBITS-1:0]         pred_target,
    input  logic [BPBITS-1:0]        pred_idx,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic [DBITS-1:0]         res_target,
    output logic                     upd_valid,
    output logic                     upd_dir,
    output logic [BPBITS-1:0]        upd_idx,
    output logic [DBITS-1:0]         upd_target,
    output logic [DBITS-1:0]         upd_pc,
    output logic                     redirect_valid,
    output logic [DBITS-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [15:0]              branch_count,
    output logic [15:0]              mispredict_count,
    output logic                     err_underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DBITS-1:0]  r_pc_mem  [DEPTH];
    logic [DBITS-1:0]  r_tgt_mem [DEPTH];
    logic [BPBITS-1:0] r_idx_mem [DEPTH];

    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              r_upd_valid;
    logic              r_upd_dir;
    logic [BPBITS-1:0] r_upd_idx;
    logic [DBITS-1:0]  r_upd_target;
    logic [DBITS-1:0]  r_upd_pc;
    logic              r_redirect_valid;
    logic [DBITS-1:0]  r_redirect_pc;
    logic [15:0]       r_branch_count;
    logic [15:0]       r_mispredict_count;
    logic              r_err_underflow;

    logic              w_push;
    logic              w_pop;
    logic              w_underflow;
    logic              w_mispredict;
    logic [DBITS-1:0]  w_head_pc;
    logic [DBITS-1:0]  w_head_tgt;
    logic [BPBITS-1:0] w_head_idx;
    logic [DBITS-1:0]  w_actual_next;

    // Oldest entry and its resolution against the actual outcome
    assign w_head_pc     = r_pc_mem[r_rptr];
    assign w_head_tgt    = r_tgt_mem[r_rptr];
    assign w_head_idx    = r_idx_mem[r_rptr];
    assign w_pop         = res_valid && (r_count != '0);
    assign w_underflow   = res_valid && (r_count == '0);
    assign w_actual_next = res_taken ? res_target : (w_head_pc + DBITS'(4));
    assign w_mispredict  = w_pop && (w_actual_next != w_head_tgt);

    // Wrong-path predictions are refused during the resolve and redirect cycles
    assign pred_ready = (r_count < CW'(DEPTH)) && !(w_mispredict || r_redirect_valid);
    assign w_push     = pred_valid && pred_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wptr]  <= pred_pc;
            r_tgt_mem[r_wptr] <= pred_target;
            r_idx_mem[r_wptr] <= pred_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr             <= '0;
            r_rptr             <= '0;
            r_count            <= '0;
            r_upd_valid        <= 1'b0;
            r_upd_dir          <= 1'b0;
            r_upd_idx          <= '0;
            r_upd_target       <= '0;
            r_upd_pc           <= '0;
            r_redirect_valid   <= 1'b0;
            r_redirect_pc      <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
            r_err_underflow    <= 1'b0;
        end else begin
            r_upd_valid      <= w_pop;
            r_redirect_valid <= w_mispredict;
            if (w_pop) begin
                r_upd_dir    <= res_taken;
                r_upd_idx    <= w_head_idx;
                r_upd_target <= res_target;
                r_upd_pc     <= w_head_pc;
            end
            if (w_mispredict) begin
                r_redirect_pc <= w_actual_next;
            end
            if (w_pop && (r_branch_count != 16'hFFFF)) begin
                r_branch_count <= r_branch_count + 16'd1;
            end
            if (w_mispredict && (r_mispredict_count != 16'hFFFF)) begin
                r_mispredict_count <= r_mispredict_count + 16'd1;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
            // A mispredict flushes every younger entry
            if (w_mispredict) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + AW'(1);
                if (w_pop)  r_rptr <= r_rptr + AW'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign upd_valid        = r_upd_valid;
    assign upd_dir          = r_upd_dir;
    assign upd_idx          = r_upd_idx;
    assign upd_target       = r_upd_target;
    assign upd_pc           = r_upd_pc;
    assign redirect_valid   = r_redirect_valid;
    assign redirect_pc      = r_redirect_pc;
    assign q_count          = r_count;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
    assign err_underflow    = r_err_underflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic checked
// against a queue-based model of the prediction/resolve rules.
module tb_branch_resolve_unit;

    localparam int unsigned DBITS  = 32;
    localparam int unsigned BPBITS = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk;
    logic              reset;
    logic              pred_valid;
    logic [31:0]       pred_pc;
    logic [31:0]       pred_target;
    logic [7:0]        pred_idx;
    logic              pred_ready;
    logic              res_valid;
    logic              res_taken;
    logic [31:0]       res_target;
    logic              upd_valid;
    logic              upd_dir;
    logic [7:0]        upd_idx;
    logic [31:0]       upd_target;
    logic [31:0]       upd_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [2:0]        q_count;
    logic [15:0]       branch_count;
    logic [15:0]       mispredict_count;
    logic              err_underflow;

    branch_resolve_unit #(.DBITS(DBITS), .BPBITS(BPBITS), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .pred_valid       (pred_valid),
        .pred_pc          (pred_pc),
        .pred_target      (pred_target),
        .pred_idx         (pred_idx),
        .pred_ready       (pred_ready),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .res_target       (res_target),
        .upd_valid        (upd_valid),
        .upd_dir          (upd_dir),
        .upd_idx          (upd_idx),
        .upd_target       (upd_target),
        .upd_pc           (upd_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .q_count          (q_count),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .err_underflow    (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [7:0]  idx;
    } ent_t;

    ent_t        mq[$];
    logic        m_upd_valid, m_upd_dir, m_redir_valid, m_err;
    logic [7:0]  m_upd_idx;
    logic [31:0] m_upd_target, m_upd_pc, m_redir_pc;
    int unsigned m_branches, m_mispredicts;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_upd_valid = 0; m_upd_dir = 0; m_upd_idx = '0; m_upd_target = '0; m_upd_pc = '0;
        m_redir_valid = 0; m_redir_pc = '0; m_err = 0;
        m_branches = 0; m_mispredicts = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".q_count"},   32'(q_count),          32'(mq.size()));
        check_eq({tag, ".upd_valid"}, 32'(upd_valid),        32'(m_upd_valid));
        check_eq({tag, ".upd_dir"},   32'(upd_dir),          32'(m_upd_dir));
        check_eq({tag, ".upd_idx"},   32'(upd_idx),          32'(m_upd_idx));
        check_eq({tag, ".upd_tgt"},   upd_target,            m_upd_target);
        check_eq({tag, ".upd_pc"},    upd_pc,                m_upd_pc);
        check_eq({tag, ".redir_v"},   32'(redirect_valid),   32'(m_redir_valid));
        check_eq({tag, ".redir_pc"},  redirect_pc,           m_redir_pc);
        check_eq({tag, ".br_cnt"},    32'(branch_count),     m_branches);
        check_eq({tag, ".mp_cnt"},    32'(mispredict_count), m_mispredicts);
        check_eq({tag, ".err"},       32'(err_underflow),    32'(m_err));
    endtask

    // One clock: drive, check ready, advance model, check registered outputs
    task automatic step(input string tag, input logic pv, input logic [31:0] pc,
                        input logic [31:0] tgt, input logic [7:0] idx,
                        input logic rv, input logic rt, input logic [31:0] rtgt);
        logic        pop, mis, ready;
        logic [31:0] actual;
        ent_t        e;
        pred_valid = pv; pred_pc = pc; pred_target = tgt; pred_idx = idx;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        #2;
        pop = rv && (mq.size() > 0);
        mis = 0;
        actual = '0;
        e = '0;
        if (pop) begin
            e = mq[0];
            actual = rt ? rtgt : e.pc + 32'd4;
            mis = (actual != e.tgt);
        end
        ready = (mq.size() < DEPTH) && !(mis || m_redir_valid);
        check_eq({tag, ".pred_ready"}, 32'(pred_ready), 32'(ready));
        m_upd_valid = pop;
        m_redir_valid = mis;
        if (pop) begin
            m_upd_dir = rt; m_upd_idx = e.idx; m_upd_target = rtgt; m_upd_pc = e.pc;
            if (m_branches < 32'hFFFF) m_branches++;
            void'(mq.pop_front());
        end
        if (mis) begin
            m_redir_pc = actual;
            if (m_mispredicts < 32'hFFFF) m_mispredicts++;
            mq.delete();
        end
        if (rv && !pop) m_err = 1;
        if (pv && ready) mq.push_back('{pc: pc, tgt: tgt, idx: idx});
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, '0, '0, '0, 0, 0, '0);
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] idx);
        step(tag, 1, pc, tgt, idx, 0, 0, '0);
    endtask

    initial begin
        reset = 0;
        pred_valid = 0; pred_pc = '0; pred_target = '0; pred_idx = '0;
        res_valid = 0; res_taken = 0; res_target = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        #1;
        check_eq("reset.pred_ready", 32'(pred_ready), 32'd1);
        check_outputs("reset");

        // Correctly predicted not-taken branch
        push("tp2_push", 32'h100, 32'h104, 8'h40);
        step("tp2_res", 0, '0, '0, '0, 1, 0, 32'h200);
        check_eq("tp2.upd_valid", 32'(upd_valid), 32'd1);
        check_eq("tp2.upd_pc", upd_pc, 32'h100);
        check_eq("tp2.upd_tgt", upd_target, 32'h200);
        check_eq("tp2.redir", 32'(redirect_valid), 32'd0);
        idle("tp2_idle");
        check_eq("tp2.upd_pulse", 32'(upd_valid), 32'd0);

        // Mispredict: squash pushes in resolve and redirect cycles
        push("tp3_push", 32'h100, 32'h104, 8'h11);
        step("tp3_res", 1, 32'h300, 32'h304, 8'h22, 1, 1, 32'h80);
        check_eq("tp3.redir_v", 32'(redirect_valid), 32'd1);
        check_eq("tp3.redir_pc", redirect_pc, 32'h80);
        check_eq("tp3.q_flush", 32'(q_count), 32'd0);
        push("tp3_redir_cyc", 32'h400, 32'h404, 8'h33);
        check_eq("tp3.redir_pulse", 32'(redirect_valid), 32'd0);
        check_eq("tp3.q_after", 32'(q_count), 32'd0);
        check_eq("tp3.mp_cnt", 32'(mispredict_count), 32'd1);

        // Fill, overfill, simultaneous pop/push when full, wrap order
        for (int i = 0; i < 5; i++)
            push("tp4_fill", 32'h1000 + 32'(i) * 32'h10, 32'h1004 + 32'(i) * 32'h10, 8'(i));
        check_eq("tp4.full", 32'(q_count), 32'd4);
        step("tp4_poppush", 1, 32'h2000, 32'h2004, 8'h50, 1, 0, '0);
        check_eq("tp4.q3", 32'(q_count), 32'd3);
        push("tp4_refill", 32'h2000, 32'h2004, 8'h50);
        check_eq("tp4.q4", 32'(q_count), 32'd4);
        for (int i = 0; i < 4; i++) step("tp4_drain", 0, '0, '0, '0, 1, 0, '0);
        check_eq("tp4.last_pc", upd_pc, 32'h2000);

        // Fall-through PC wraps to zero
        push("tp5_push", 32'hFFFF_FFFC, 32'h0, 8'hAA);
        step("tp5_res", 0, '0, '0, '0, 1, 0, 32'h1234);
        check_eq("tp5.no_redir", 32'(redirect_valid), 32'd0);

        // Underflow is sticky, then asynchronous reset mid-stream
        step("tp6_under", 0, '0, '0, '0, 1, 1, 32'h55);
        check_eq("tp6.err", 32'(err_underflow), 32'd1);
        idle("tp6_idle");
        check_eq("tp6.err_sticky", 32'(err_underflow), 32'd1);
        push("tp6_p0", 32'h500, 32'h504, 8'h01);
        push("tp6_p1", 32'h510, 32'h514, 8'h02);
        #2;
        reset = 0;
        model_clear();
        #1;
        check_eq("tp6.rst_q", 32'(q_count), 32'd0);
        check_eq("tp6.rst_err", 32'(err_underflow), 32'd0);
        check_outputs("tp6_rst");
        @(posedge clk);
        #1;
        reset = 1;

        // Random traffic with biased-correct resolutions
        for (int n = 0; n < 2000; n++) begin
            logic        pv, rv, rt;
            logic [31:0] pc, tgt, rtgt;
            pv = ($urandom_range(0, 9) < 6);
            rv = ($urandom_range(0, 9) < 4);
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            tgt = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            rt = 1'($urandom_range(0, 1));
            rtgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if (mq.size() > 0 && $urandom_range(0, 9) < 7) begin
                rt = (mq[0].tgt != mq[0].pc + 32'd4);
                if (rt) rtgt = mq[0].tgt;
            end
            step("rnd", pv, pc, tgt, 8'($urandom), rv, rt, rtgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
